// File: rtl/arp_reply_engine.sv
// Purpose: answers ARP requests for LOCAL_IP with an ARP reply and can send gratuitous ARP announcements.
// Latency: the first reply word is valid in the cycle after the last request word is accepted.
// Backpressure: the reply holds while i_tx_ready is low; o_arp_ready is low during TX and when a GARP is due.
module arp_reply_engine #(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0001,
    parameter bit          EN_GARP   = 1'b1,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      i_arp_data,
    input  logic             i_arp_valid,
    input  logic             i_arp_last,
    output logic             o_arp_ready,
    output logic [31:0]      o_tx_data,
    output logic             o_tx_valid,
    output logic             o_tx_last,
    input  logic             i_tx_ready,
    input  logic             i_garp_req,
    output logic [CNT_W-1:0] o_req_cnt,
    output logic [CNT_W-1:0] o_reply_cnt,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam logic [31:0]      ARP_W0    = 32'h0001_0800;  // Ethernet / IPv4
    localparam logic [31:0]      ARP_REQ1  = 32'h0604_0001;  // hlen/plen, oper=request
    localparam logic [31:0]      ARP_REP1  = 32'h0604_0002;  // hlen/plen, oper=reply
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {ST_RX, ST_DRAIN, ST_TX} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  rx_idx;       // saturates at 7 while padding is consumed
    logic [2:0]  tx_idx;
    logic [47:0] sha;
    logic [31:0] spa;
    logic        tx_garp;      // current TX burst is a gratuitous ARP
    logic        garp_pend;
    logic        garp_start;
    logic        rx_fire;
    logic        tx_fire;
    logic        word_bad;
    logic        req_inc;
    logic        drop_inc;
    logic        reply_inc;
    logic [31:0] tx_word;

    assign rx_fire = i_arp_valid & o_arp_ready;
    assign tx_fire = o_tx_valid & i_tx_ready;

    // A frame is bad as soon as a header word or the target IP mismatches.
    always_comb begin
        word_bad = 1'b0;
        case (rx_idx)
            3'd0:    word_bad = (i_arp_data != ARP_W0);
            3'd1:    word_bad = (i_arp_data != ARP_REQ1);
            3'd6:    word_bad = (i_arp_data != LOCAL_IP);
            default: word_bad = 1'b0;
        endcase
    end

    // Reply word selection; a GARP carries our own IP as target and zero THA.
    always_comb begin
        tx_word = 32'h0;
        case (tx_idx)
            3'd0:    tx_word = ARP_W0;
            3'd1:    tx_word = tx_garp ? ARP_REQ1 : ARP_REP1;
            3'd2:    tx_word = LOCAL_MAC[47:16];
            3'd3:    tx_word = {LOCAL_MAC[15:0], LOCAL_IP[31:16]};
            3'd4:    tx_word = {LOCAL_IP[15:0], (tx_garp ? 16'h0 : sha[47:32])};
            3'd5:    tx_word = tx_garp ? 32'h0 : sha[31:0];
            3'd6:    tx_word = tx_garp ? LOCAL_IP : spa;
            default: tx_word = 32'h0;
        endcase
    end

    // Next-state and stream outputs.
    always_comb begin
        state_nxt   = state;
        o_arp_ready = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_last   = 1'b0;
        o_tx_data   = 32'h0;
        garp_start  = 1'b0;
        req_inc     = 1'b0;
        drop_inc    = 1'b0;
        reply_inc   = 1'b0;
        case (state)
            ST_RX: begin
                if (garp_pend && (rx_idx == 3'd0)) begin
                    garp_start = 1'b1;
                    state_nxt  = ST_TX;
                end else begin
                    o_arp_ready = 1'b1;
                    if (i_arp_valid) begin
                        if (i_arp_last) begin
                            if ((rx_idx >= 3'd6) && !word_bad) begin
                                req_inc   = 1'b1;
                                state_nxt = ST_TX;
                            end else begin
                                drop_inc = 1'b1;
                            end
                        end else if (word_bad) begin
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                o_arp_ready = 1'b1;
                if (i_arp_valid && i_arp_last) begin
                    drop_inc  = 1'b1;
                    state_nxt = ST_RX;
                end
            end
            ST_TX: begin
                o_tx_valid = 1'b1;
                o_tx_data  = tx_word;
                o_tx_last  = (tx_idx == 3'd6);
                if (i_tx_ready && (tx_idx == 3'd6)) begin
                    reply_inc = 1'b1;
                    state_nxt = ST_RX;
                end
            end
            default: state_nxt = ST_RX;
        endcase
    end

    // State, word indices and GARP/reply selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RX;
            rx_idx  <= 3'd0;
            tx_idx  <= 3'd0;
            tx_garp <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rx_fire) begin
                if (i_arp_last)
                    rx_idx <= 3'd0;
                else if (rx_idx != 3'd7)
                    rx_idx <= rx_idx + 3'd1;
            end
            if (state != ST_TX)
                tx_idx <= 3'd0;
            else if (tx_fire)
                tx_idx <= tx_idx + 3'd1;
            if (garp_start)
                tx_garp <= 1'b1;
            else if (req_inc)
                tx_garp <= 1'b0;
        end
    end

    // Capture sender hardware and protocol addresses from words 2..4.
    always_ff @(posedge clk) begin
        if (rst) begin
            sha <= 48'h0;
            spa <= 32'h0;
        end else if (rx_fire && (state == ST_RX)) begin
            case (rx_idx)
                3'd2:    sha[47:16] <= i_arp_data;
                3'd3:    {sha[15:0], spa[31:16]} <= i_arp_data;
                3'd4:    spa[15:0] <= i_arp_data[31:16];
                default: ;
            endcase
        end
    end

    generate
        if (EN_GARP) begin : g_garp
            // Pending request; repeats while pending or while a GARP is on the wire merge into one.
            always_ff @(posedge clk) begin
                if (rst)
                    garp_pend <= 1'b0;
                else if (garp_start)
                    garp_pend <= 1'b0;
                else if (i_garp_req && !((state == ST_TX) && tx_garp))
                    garp_pend <= 1'b1;
            end
        end else begin : g_no_garp
            assign garp_pend = 1'b0;
        end
    endgenerate

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_req_cnt   <= '0;
            o_reply_cnt <= '0;
            o_drop_cnt  <= '0;
        end else begin
            if (req_inc && (o_req_cnt != CNT_MAX))
                o_req_cnt <= o_req_cnt + 1'b1;
            if (reply_inc && (o_reply_cnt != CNT_MAX))
                o_reply_cnt <= o_reply_cnt + 1'b1;
            if (drop_inc && (o_drop_cnt != CNT_MAX))
                o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_arp_reply_engine.sv
// Purpose: self-checking bench for arp_reply_engine against a packet-level ARP model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: i_tx_ready is stalled by the directed stimulus; a stall must hold the reply word.
module tb_arp_reply_engine;

    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] LIP  = 32'hC0A8_0001;
    localparam int          CW   = 3;
    localparam int          CMAX = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   i_arp_data = '0;
    logic          i_arp_valid = 1'b0;
    logic          i_arp_last = 1'b0;
    logic          o_arp_ready;
    logic [31:0]   o_tx_data;
    logic          o_tx_valid;
    logic          o_tx_last;
    logic          i_tx_ready = 1'b1;
    logic          i_garp_req = 1'b0;
    logic [CW-1:0] o_req_cnt;
    logic [CW-1:0] o_reply_cnt;
    logic [CW-1:0] o_drop_cnt;

    always #5 clk = ~clk;

    arp_reply_engine #(.LOCAL_MAC(LMAC), .LOCAL_IP(LIP), .EN_GARP(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_arp_data(i_arp_data), .i_arp_valid(i_arp_valid), .i_arp_last(i_arp_last),
        .o_arp_ready(o_arp_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last),
        .i_tx_ready(i_tx_ready), .i_garp_req(i_garp_req),
        .o_req_cnt(o_req_cnt), .o_reply_cnt(o_reply_cnt), .o_drop_cnt(o_drop_cnt)
    );

    typedef struct { logic [31:0] d; bit l; bit g; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] seen[$];
    int          ncmp = 0;
    int          nbad = 0;
    int          m_req = 0, m_drop = 0, m_reply = 0;
    int          beats = 0;
    bit          garp_owed = 1'b0;
    logic [31:0] fw[12];
    int          fn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic push_pkt(input logic [31:0] p[7], input bit g);
        for (int k = 0; k < 7; k++) exp_q.push_back('{d: p[k], l: (k == 6), g: g});
    endtask

    // Build a 7-word ARP request in fw.
    task automatic mk_req(input logic [47:0] s_ha, input logic [31:0] s_pa, input logic [31:0] t_pa);
        fw[0] = 32'h0001_0800;
        fw[1] = 32'h0604_0001;
        fw[2] = s_ha[47:16];
        fw[3] = {s_ha[15:0], s_pa[31:16]};
        fw[4] = {s_pa[15:0], 16'h0000};
        fw[5] = 32'h0;
        fw[6] = t_pa;
        for (int k = 7; k < 12; k++) fw[k] = 32'h5A5A_0000 + k;
        fn = 7;
    endtask

    // Model: decide the frame's fate from ARP rules, then stream it in.
    task automatic send_frame();
        bit          good;
        bit          acc;
        int          guard;
        logic [47:0] s_ha;
        logic [31:0] s_pa;
        logic [31:0] rep[7];
        good = (fn >= 7) && (fw[0] == 32'h0001_0800) && (fw[1] == 32'h0604_0001) && (fw[6] == LIP);
        if (good) begin
            s_ha = {fw[2], fw[3][31:16]};
            s_pa = {fw[3][15:0], fw[4][31:16]};
            rep[0] = 32'h0001_0800;
            rep[1] = 32'h0604_0002;
            rep[2] = LMAC[47:16];
            rep[3] = {LMAC[15:0], LIP[31:16]};
            rep[4] = {LIP[15:0], s_ha[47:32]};
            rep[5] = s_ha[31:0];
            rep[6] = s_pa;
            push_pkt(rep, 1'b0);
            m_req++;
        end else begin
            m_drop++;
        end
        for (int k = 0; k < fn; k++) begin
            i_arp_data  = fw[k];
            i_arp_valid = 1'b1;
            i_arp_last  = (k == fn - 1);
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = o_arp_ready;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 200) begin
                    chk("rx_accept_timeout", {31'b0, o_arp_ready}, 32'd1);
                    i_arp_valid = 1'b0;
                    i_arp_last  = 1'b0;
                    return;
                end
            end
        end
        i_arp_valid = 1'b0;
        i_arp_last  = 1'b0;
    endtask

    task automatic pulse_garp();
        logic [31:0] g[7];
        g[0] = 32'h0001_0800;
        g[1] = 32'h0604_0001;
        g[2] = LMAC[47:16];
        g[3] = {LMAC[15:0], LIP[31:16]};
        g[4] = {LIP[15:0], 16'h0000};
        g[5] = 32'h0;
        g[6] = LIP;
        i_garp_req = 1'b1;
        if (!garp_owed) begin
            push_pkt(g, 1'b1);
            garp_owed = 1'b1;
        end
        @(posedge clk);
        #1;
        i_garp_req = 1'b0;
    endtask

    task automatic wait_beats(input int b);
        for (int c = 0; c < 100; c++) begin
            if (beats == b && o_tx_valid) return;
            @(posedge clk);
            #1;
        end
        chk("wait_beats_timeout", beats, b);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !o_tx_valid) begin
                repeat (3) @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("idle_timeout_pending_words", exp_q.size(), 0);
    endtask

    task automatic check_cnts(input string tag);
        chk({tag, "_req_cnt"},   {29'b0, o_req_cnt},   sat(m_req));
        chk({tag, "_reply_cnt"}, {29'b0, o_reply_cnt}, sat(m_reply));
        chk({tag, "_drop_cnt"},  {29'b0, o_drop_cnt},  sat(m_drop));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_req = 0; m_drop = 0; m_reply = 0;
        beats = 0;
        garp_owed = 1'b0;
    endtask

    // Compare process: every transferred reply word against the model queue, plus hold-under-stall.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat;
    logic        prev_last;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", {31'b0, o_tx_valid}, 32'd1);
                chk("stall_data_held", o_tx_data, prev_dat);
                chk("stall_last_held", {31'b0, o_tx_last}, {31'b0, prev_last});
            end
            if (o_tx_valid && i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected_word", {31'b0, o_tx_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", o_tx_data, e.d);
                    chk("tx_last", {31'b0, o_tx_last}, {31'b0, e.l});
                    seen.push_back(o_tx_data);
                    beats++;
                    if (e.l) begin
                        beats = 0;
                        m_reply++;
                        if (e.g) garp_owed = 1'b0;
                    end
                end
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_dat   = o_tx_data;
            prev_last  = o_tx_last;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_arp_ready", {31'b0, o_arp_ready}, 32'd1);
        chk("rst_tx_valid",  {31'b0, o_tx_valid},  32'd0);
        chk("rst_tx_last",   {31'b0, o_tx_last},   32'd0);
        chk("rst_tx_data",   o_tx_data,            32'd0);
        check_cnts("rst");

        // Basic request and hand-computed reply words.
        seen.delete();
        mk_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0002, LIP);
        send_frame();
        wait_idle();
        chk("basic_len", seen.size(), 32'd7);
        chk("basic_w1", seen[1], 32'h0604_0002);
        chk("basic_w2", seen[2], 32'h0200_0000);
        chk("basic_w3", seen[3], 32'h0001_C0A8);
        chk("basic_w4", seen[4], 32'h0001_AABB);
        chk("basic_w5", seen[5], 32'hCCDD_EEFF);
        chk("basic_w6", seen[6], 32'hC0A8_0002);
        check_cnts("basic");

        // Foreign target IP is dropped; the next valid frame is answered.
        mk_req(48'h1122_3344_5566, 32'h0A00_0001, 32'hC0A8_0009);
        send_frame();
        wait_idle();
        check_cnts("wrong_tpa");
        chk("wrong_tpa_drop_lit", {29'b0, o_drop_cnt}, 32'd1);
        mk_req(48'h1122_3344_5566, 32'h0A00_0001, LIP);
        send_frame();
        wait_idle();
        check_cnts("after_drop");

        // Runt frame, then a padded valid frame.
        mk_req(48'h0102_0304_0506, 32'hC0A8_0003, LIP);
        fn = 5;
        send_frame();
        mk_req(48'h0102_0304_0506, 32'hC0A8_0003, LIP);
        fn = 10;
        send_frame();
        wait_idle();
        check_cnts("runt_pad");

        // Bad ethertype detected early: discarded through to last.
        mk_req(48'h0102_0304_0506, 32'hC0A8_0004, LIP);
        fw[0] = 32'h0001_86DD;
        fn = 9;
        send_frame();
        wait_idle();
        check_cnts("drain");

        // Output stall of 5 cycles on word 3.
        mk_req(48'hDEAD_BEEF_0001, 32'hC0A8_0005, LIP);
        send_frame();
        wait_beats(3);
        i_tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        i_tx_ready = 1'b1;
        wait_idle();
        check_cnts("stall");

        // Reset while reply word 4 is on the bus.
        mk_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0006, LIP);
        send_frame();
        wait_beats(4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midtx_rst_valid", {31'b0, o_tx_valid}, 32'd0);
        chk("midtx_rst_data",  o_tx_data, 32'd0);
        model_reset();
        check_cnts("midtx_rst");
        rst = 1'b0;
        mk_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0007, LIP);
        send_frame();
        wait_idle();
        check_cnts("after_rst");

        // Two GARP pulses during a reply merge into one GARP after it.
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        seen.delete();
        mk_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0002, LIP);
        send_frame();
        wait_beats(2);
        pulse_garp();
        @(posedge clk);
        #1;
        pulse_garp();
        wait_idle();
        chk("garp_len", seen.size(), 32'd14);
        chk("garp_w1",  seen[8],  32'h0604_0001);
        chk("garp_w4",  seen[11], 32'h0001_0000);
        chk("garp_w6",  seen[13], 32'hC0A8_0001);
        chk("garp_reply_lit", {29'b0, o_reply_cnt}, 32'd2);
        check_cnts("garp");

        // Push counters past the 3-bit limit to check saturation.
        for (int f = 0; f < 6; f++) begin
            mk_req(48'h0000_0000_1000 + f, 32'hC0A8_0100 + f, LIP);
            send_frame();
            wait_idle();
        end
        check_cnts("saturate");
        chk("saturate_reply_lit", {29'b0, o_reply_cnt}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/arp_reply_engine.md
ARP_REPLY_ENGINE -- requirements
Module: arp_reply_engine

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h02_00_00_00_00_01, station MAC inserted as SHA in replies.
REQ-002 SHALL have parameter LOCAL_IP, default 32'hC0A8_0001, station IP matched against TPA and inserted as SPA.
REQ-003 SHALL have parameter EN_GARP, default 1, enables the gratuitous-ARP transmit mode.
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports i_arp_data in 32, i_arp_valid in 1, i_arp_last in 1, o_arp_ready out 1: ARP payload stream, big-endian, word 0 first.
REQ-008 SHALL have ports o_tx_data out 32, o_tx_valid out 1, o_tx_last out 1, i_tx_ready in 1: reply payload stream.
REQ-009 SHALL have port i_garp_req  in  1  single-cycle gratuitous-ARP request.
REQ-010 SHALL have ports o_req_cnt, o_reply_cnt, o_drop_cnt, each out CNT_W: matched requests, replies sent (incl. GARP), dropped frames.

Function
REQ-011 Transfer occurs when valid and ready are both high in one cycle, on either stream.
REQ-012 States: RX, DRAIN, TX; reset state RX.
REQ-013 RX: o_arp_ready=1; word index 0..6 counts accepted words; words 2,3,4,6 latched (SHA, SPA, TPA).
REQ-014 Match: W0==32'h0001_0800, W1==32'h0604_0001, W6==LOCAL_IP; any W0/W1 mismatch or mismatching TPA marks frame bad.
REQ-015 Words beyond index 6 (padding) SHALL be accepted and ignored until i_arp_last.
REQ-016 i_arp_last on a word with index <6 SHALL mark frame bad (runt).
REQ-017 On accepted i_arp_last: good frame -> o_req_cnt+1, TX in next cycle; bad frame -> o_drop_cnt+1, stay RX, index reset to 0.
REQ-018 Early-detected bad frame before last SHALL move to DRAIN; DRAIN keeps o_arp_ready=1, discards until last, then counts drop, returns RX.
REQ-019 TX: o_arp_ready=0; 7 words emitted: 32'h0001_0800, 32'h0604_0002, LOCAL_MAC[47:16], {LOCAL_MAC[15:0],LOCAL_IP[31:16]}, {LOCAL_IP[15:0],SHA[47:32]}, SHA[31:0], SPA.
REQ-020 First reply word valid in cycle after the last input word is accepted; o_tx_data/o_tx_last SHALL hold while o_tx_valid=1 and i_tx_ready=0.
REQ-021 o_tx_last=1 only on word 6; on its transfer o_reply_cnt+1, state returns RX next cycle.
REQ-022 GARP (EN_GARP=1): i_garp_req sets a pending flag; flag serviced only in RX with word index 0; sends W1=32'h0604_0001, SHA=LOCAL_MAC, SPA=TPA=LOCAL_IP, THA=0.
REQ-023 GARP pending SHALL block new RX frames (o_arp_ready=0) only while index is 0; requests during a pending/active GARP merge into one.
REQ-024 If a frame reply and a GARP both become due in one cycle, the frame reply goes first, GARP follows.
REQ-025 EN_GARP=0: i_garp_req ignored, no pending flag logic.
REQ-026 Counters saturate at all-ones, no wrap.

Reset
REQ-027 On rst: state RX, index 0, GARP pending 0, all counters 0, o_tx_valid=0, o_tx_last=0, o_tx_data=0, o_arp_ready=1 from the first cycle after reset.
REQ-028 rst mid-frame or mid-TX SHALL abort immediately; partial frame discarded, no counter change.

Verification
REQ-029 Valid 7-word request, TPA=C0A80001, SHA=AABBCCDDEEFF, SPA=C0A80002 -> reply words per REQ-019 ending C0A80002, last on word 6, reply_cnt=1.
REQ-030 Request with TPA=C0A80009 -> no o_tx_valid, drop_cnt=1, next valid frame answered.
REQ-031 5-word frame with last on word 4 -> drop_cnt=1, no reply; 10-word padded valid frame -> one reply.
REQ-032 i_tx_ready held 0 for 5 cycles on word 3 -> o_tx_data stable, no word lost or duplicated.
REQ-033 i_garp_req pulsed twice during a reply -> exactly one GARP after reply, W6=C0A80001, reply_cnt=2.
REQ-034 rst asserted at reply word 4 -> o_tx_valid=0 next cycle, counters 0, new request answered normally.
